nios2_ocimem_arbiter: RTL and testbench
=======================================

Name: nios2_ocimem_arbiter

Overview:
- Sysclk-domain controller that shares the single-port on-chip debug RAM (OCI memory) between two requesters.
- Requester 1: the JTAG debug path, which issues decoded take_action/take_no_action pulses plus jdo.
- Requester 2: the CPU debug Avalon slave.
- Sequences RAM cycles, returns read data to MonDReg/monitor_ready for JTAG capture, and stalls the CPU with waitrequest.
- Sits between the debug-module sysclk decoder and the OCI RAM instance.

Parameters:
- ADDR_W, 8, RAM word-address width (256 x 32 words).
- JTAG_PRIO, 0, 0 = round-robin arbitration; 1 = JTAG always wins ties.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jdo  in  38  JTAG debug data, already synchronized to clk
- jtag_ld_addr  in  1  1-cycle pulse: load JTAG address from jdo[17+ADDR_W-1:17], clear monitor_ready
- jtag_wr  in  1  1-cycle pulse: write jdo[34:3] at JTAG address
- jtag_rd  in  1  1-cycle pulse: read at JTAG address into MonDReg
- MonDReg  out  32  last JTAG read data / echoed write data
- monitor_ready  out  1  JTAG transaction complete
- monitor_error  out  1  sticky: JTAG request dropped (overrun)
- cpu_address  in  ADDR_W  Avalon word address
- cpu_read  in  1  Avalon read
- cpu_write  in  1  Avalon write
- cpu_writedata  in  32  Avalon write data
- cpu_byteenable  in  4  Avalon byte enables
- cpu_debugaccess  in  1  write permitted only when 1
- cpu_readdata  out  32  Avalon read data
- cpu_waitrequest  out  1  Avalon stall
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_be  out  4  RAM byte enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data; 1-cycle latency after address

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - MonDReg=0, monitor_ready=0, monitor_error=0
  - cpu_readdata=0, cpu_waitrequest=1
  - ram_we=0, ram_addr=0, ram_be=0, ram_wdata=0
  - JTAG address=0, JTAG pending slot empty, FSM=IDLE, last_grant=CPU (so JTAG wins the first tie)
- JTAG pending slot:
  - 1 entry: op rd/wr, plus data.
  - A jtag_rd or jtag_wr pulse fills the slot and clears monitor_ready.
  - A pulse arriving while the slot is full or a JTAG op is in flight is dropped and sets monitor_error. monitor_error clears only on reset or jtag_ld_addr.
- jtag_ld_addr:
  - Takes effect immediately.
  - If the same cycle also carries jtag_rd/jtag_wr, the new address is used for that op.
  - A jtag_ld_addr during an in-flight JTAG op does not alter that op's address.
- FSM states: IDLE, CPU_RD, JTAG_RD.
  - IDLE, candidates: CPU request = cpu_read|cpu_write; JTAG request = slot full.
    - JTAG_PRIO=1: JTAG wins if present.
    - Otherwise, on a tie the winner is the requester that is not last_grant.
    - last_grant updates on every grant.
  - CPU write granted:
    - ram_we = cpu_debugaccess, ram_be = cpu_byteenable, data/address driven that cycle.
    - cpu_waitrequest=0 that same cycle; stay IDLE.
    - A write with debugaccess=0 completes but does not modify RAM.
  - CPU read granted:
    - Drive ram_addr; go to CPU_RD.
    - In CPU_RD: cpu_readdata=ram_rdata, cpu_waitrequest=0 for one cycle, then IDLE. Read latency = 2 cycles from request.
  - JTAG write granted:
    - ram_we=1, ram_be=4'hF, MonDReg=written data.
    - monitor_ready=1 the next cycle; slot emptied; stay IDLE.
  - JTAG read granted:
    - Go to JTAG_RD.
    - Next cycle: MonDReg=ram_rdata, monitor_ready=1; slot emptied; back to IDLE.
- cpu_waitrequest is 1 in every cycle without a CPU completion, including while a CPU request is idle-pending.
- Fairness: the CPU may hold its request asserted indefinitely. Round-robin guarantees JTAG service within 3 cycles.
- Back-to-back grants: a new grant can be issued in IDLE directly after a write (1 op/cycle) or after any *_RD state.
- ram_we is never asserted in CPU_RD or JTAG_RD.
- Reset mid-operation: any in-flight op is abandoned. No RAM write may occur in the reset cycle (ram_we forced 0).

Optional Feature:
- Macro: NIOS2_OCIMEM_AUTOINC_EN.
- Defined: JTAG address increments by 1 (mod 2^ADDR_W, wraps 255->0) after each completed JTAG read or write.
- Undefined: JTAG address changes only on jtag_ld_addr.

Decomposition:
- Shared package nios2_ocimem_pkg:
  - arb_state_t enum {IDLE, CPU_RD, JTAG_RD}
  - jtag_op_t {op_wr, data[31:0]}
  - constants JDO_ADDR_LSB=17, JDO_DATA_LSB=3
- Sub-module nios2_ocimem_jtag_slot: pending slot, overrun/error logic and address counter (autoinc under macro). The arbiter FSM stays in the top.

Test Plan:
- Reset, idle: after reset -> cpu_waitrequest=1, monitor_ready=0, MonDReg=0, ram_we=0.
- JTAG write then read: ld_addr jdo addr=8'h10; jtag_wr data 32'hDEADBEEF; jtag_rd -> RAM[0x10]=DEADBEEF; MonDReg=DEADBEEF with monitor_ready=1 one cycle after JTAG_RD. With AUTOINC, the read targets 0x11.
- Simultaneous requests: CPU read 0x20 and JTAG read 0x30 in the same cycle after reset -> JTAG granted first; CPU waitrequest drops at cycle 4; next tie goes to CPU.
- Write protection: CPU write 0x05 data 0x12345678, be=4'b0011, debugaccess=0 -> waitrequest=0 in 1 cycle, RAM unchanged. Repeat with debugaccess=1 -> only the low 16 bits are written.
- Overrun: two jtag_rd pulses 1 cycle apart while the CPU holds a read -> second pulse dropped, monitor_error=1; cleared by jtag_ld_addr.
- Wrap and mid-op reset: AUTOINC, addr 0xFF, jtag_wr -> address becomes 0x00. reset asserted during CPU_RD -> FSM IDLE, waitrequest=1, no RAM write.

Source files
------------

// File: rtl/nios2_ocimem_pkg.sv
// Shared types and constants for the OCI debug RAM arbiter.
package nios2_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    JTAG_RD = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        op_wr;
    logic [31:0] data;
  } jtag_op_t;

  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_LSB = 3;

endpackage

// File: rtl/nios2_ocimem_jtag_slot.sv
// JTAG side of the OCI RAM arbiter: one-entry pending slot, overrun flag and
// the JTAG address register.
// Optional macro: NIOS2_OCIMEM_AUTOINC_EN -- when defined, the JTAG address
// steps by one (wrapping) after every completed JTAG read or write.
module nios2_ocimem_jtag_slot
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              ld_addr,
  input  logic              wr,
  input  logic              rd,
  input  logic              done,
  output logic              full,
  output jtag_op_t          op,
  output logic [ADDR_W-1:0] op_addr,
  output logic              accept,
  output logic              error
);

  logic [ADDR_W-1:0] jtag_addr;
  logic [ADDR_W-1:0] new_addr;
  logic              pulse;
  logic              drop;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // An address loaded in the same cycle as an op applies to that op.
  assign new_addr = ld_addr ? jdo[JDO_ADDR_LSB +: ADDR_W] : jtag_addr;
  assign pulse    = wr | rd;
  // The slot stays full until its op completes, so a full slot also covers
  // the in-flight case.
  assign accept   = pulse & ~full;
  assign drop     = pulse & full;

  // Slot contents: address is captured at fill time so later loads leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 1'b0;
      op      <= '0;
      op_addr <= '0;
    end else if (accept) begin
      full     <= 1'b1;
      op.op_wr <= wr;
      op.data  <= jdo[JDO_DATA_LSB +: 32];
      op_addr  <= new_addr;
    end else if (done) begin
      full <= 1'b0;
    end
  end

  // JTAG address register; a load wins over auto-increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_addr <= '0;
    end else if (ld_addr) begin
      jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
`ifdef NIOS2_OCIMEM_AUTOINC_EN
    end else if (done) begin
      jtag_addr <= jtag_addr + ADDR_W'(1);
`endif
    end
  end

  // Sticky overrun flag; a dropped pulse wins over a clearing address load.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (drop) begin
      error <= 1'b1;
    end else if (ld_addr) begin
      error <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path and the
// CPU debug Avalon slave. RAM-side outputs are combinational from the grant
// so a write completes in its grant cycle; reads take one extra state.
// Optional macro: NIOS2_OCIMEM_AUTOINC_EN (JTAG address auto-increment,
// implemented in nios2_ocimem_jtag_slot).
module nios2_ocimem_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int JTAG_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              jtag_ld_addr,
  input  logic              jtag_wr,
  input  logic              jtag_rd,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  input  logic              cpu_debugaccess,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  arb_state_t        state, nxt_state;
  logic              last_jtag;
  logic              cpu_req;
  logic              grant_cpu, grant_jtag;
  logic              jtag_done;
  logic              slot_full, slot_accept;
  jtag_op_t          slot_op;
  logic [ADDR_W-1:0] slot_addr;

  nios2_ocimem_jtag_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk     (clk),
    .reset   (reset),
    .jdo     (jdo),
    .ld_addr (jtag_ld_addr),
    .wr      (jtag_wr),
    .rd      (jtag_rd),
    .done    (jtag_done),
    .full    (slot_full),
    .op      (slot_op),
    .op_addr (slot_addr),
    .accept  (slot_accept),
    .error   (monitor_error)
  );

  assign cpu_req = cpu_read | cpu_write;

  // Arbitration, next state and RAM/Avalon drive; everything quiet in reset.
  always_comb begin
    nxt_state       = state;
    grant_cpu       = 1'b0;
    grant_jtag      = 1'b0;
    jtag_done       = 1'b0;
    ram_addr        = '0;
    ram_we          = 1'b0;
    ram_be          = '0;
    ram_wdata       = '0;
    cpu_readdata    = '0;
    cpu_waitrequest = 1'b1;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (slot_full && (!cpu_req || (JTAG_PRIO != 0) || !last_jtag))
            grant_jtag = 1'b1;
          else if (cpu_req)
            grant_cpu = 1'b1;

          if (grant_jtag) begin
            ram_addr = slot_addr;
            if (slot_op.op_wr) begin
              ram_we    = 1'b1;
              ram_be    = 4'hF;
              ram_wdata = slot_op.data;
              jtag_done = 1'b1;
            end else begin
              nxt_state = JTAG_RD;
            end
          end else if (grant_cpu) begin
            ram_addr = cpu_address;
            if (cpu_write) begin
              // Without debugaccess the write is acknowledged but discarded.
              ram_we          = cpu_debugaccess;
              ram_be          = cpu_byteenable;
              ram_wdata       = cpu_writedata;
              cpu_waitrequest = 1'b0;
            end else begin
              nxt_state = CPU_RD;
            end
          end
        end
        CPU_RD: begin
          cpu_readdata    = ram_rdata;
          cpu_waitrequest = 1'b0;
          nxt_state       = IDLE;
        end
        JTAG_RD: begin
          jtag_done = 1'b1;
          nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // FSM state and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_jtag <= 1'b0;
    end else begin
      state <= nxt_state;
      if (grant_jtag)
        last_jtag <= 1'b1;
      else if (grant_cpu)
        last_jtag <= 1'b0;
    end
  end

  // JTAG result capture; a completion wins over a clearing pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
    end else begin
      if (state == JTAG_RD)
        MonDReg <= ram_rdata;
      else if (grant_jtag && slot_op.op_wr)
        MonDReg <= slot_op.data;

      if (jtag_done)
        monitor_ready <= 1'b1;
      else if (slot_accept || jtag_ld_addr)
        monitor_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter with a behavioural 256x32 RAM
// (1-cycle read latency). Unwritten words read back as 32'hC0DE0000 | addr.
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge of the same cycle.
module tb_nios2_ocimem_arbiter;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        jtag_ld_addr, jtag_wr, jtag_rd;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_debugaccess;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        mem_clr;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  nios2_ocimem_arbiter #(.ADDR_W(8), .JTAG_PRIO(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .jdo             (jdo),
    .jtag_ld_addr    (jtag_ld_addr),
    .jtag_wr         (jtag_wr),
    .jtag_rd         (jtag_rd),
    .MonDReg         (MonDReg),
    .monitor_ready   (monitor_ready),
    .monitor_error   (monitor_error),
    .cpu_address     (cpu_address),
    .cpu_read        (cpu_read),
    .cpu_write       (cpu_write),
    .cpu_writedata   (cpu_writedata),
    .cpu_byteenable  (cpu_byteenable),
    .cpu_debugaccess (cpu_debugaccess),
    .cpu_readdata    (cpu_readdata),
    .cpu_waitrequest (cpu_waitrequest),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_be          (ram_be),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [37:0] jaddr(input logic [7:0] a);
    return 38'(a) << 17;
  endfunction

  function automatic logic [37:0] jdata(input logic [31:0] d);
    return 38'(d) << 3;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
    jtag_ld_addr = 1'b0;
    jtag_wr      = 1'b0;
    jtag_rd      = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1;
    jdo = '0; jtag_ld_addr = 0; jtag_wr = 0; jtag_rd = 0;
    cpu_address = 8'h00; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
    cpu_byteenable = 4'h0; cpu_debugaccess = 0;
    nxt(); nxt();
    cpu_write = 1; cpu_debugaccess = 1; cpu_byteenable = 4'hF; cpu_writedata = 32'hFFFFFFFF;
    mid();
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we_in_reset: got %0h exp 0", ram_we); end
    total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait_in_reset: got %0h exp 1", cpu_waitrequest); end
    nxt(); reset = 0; mem_clr = 0; cpu_write = 0; cpu_debugaccess = 0; cpu_byteenable = 4'h0;
    mid();
    total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait: got %0h exp 1", cpu_waitrequest); end
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0h exp 0", monitor_ready); end
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %0h exp 0", monitor_error); end
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL rst_mondreg: got %h exp 0", MonDReg); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %0h exp 0", ram_we); end
    total++; if (cpu_readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h exp 0", cpu_readdata); end
  endtask

  task automatic test_jtag_wr_rd();
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef NIOS2_OCIMEM_AUTOINC_EN
    rd_addr = 8'h11; rd_data = 32'hC0DE0011;
`else
    rd_addr = 8'h10; rd_data = 32'hDEADBEEF;
`endif
    nxt(); jtag_ld_addr = 1; jdo = jaddr(8'h10);
    nxt(); jtag_wr = 1; jdo = jdata(32'hDEADBEEF);
    mid();
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL jw_ready_early: got %0h exp 0", monitor_ready); end
    nxt();
    mid();
    total++; if ({ram_we, ram_be, ram_addr} !== {1'b1, 4'hF, 8'h10}) begin bad++; $display("FAIL jw_ram_ctl: got %0h/%0h/%0h exp 1/f/10", ram_we, ram_be, ram_addr); end
    total++; if (ram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL jw_wdata: got %h exp deadbeef", ram_wdata); end
    nxt(); jtag_rd = 1;
    mid();
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL jw_ready: got %0h exp 1", monitor_ready); end
    total++; if (MonDReg !== 32'hDEADBEEF) begin bad++; $display("FAIL jw_mondreg: got %h exp deadbeef", MonDReg); end
    total++; if (mem[8'h10] !== 32'hDEADBEEF) begin bad++; $display("FAIL jw_mem: got %h exp deadbeef", mem[8'h10]); end
    nxt();
    mid();
    total++; if (ram_addr !== rd_addr || ram_we !== 1'b0) begin bad++; $display("FAIL jr_grant: got addr %h we %0h exp addr %h we 0", ram_addr, ram_we, rd_addr); end
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL jr_ready_clr: got %0h exp 0", monitor_ready); end
    nxt();
    mid();
    total++; if (ram_we !== 1'b0 || monitor_ready !== 1'b0) begin bad++; $display("FAIL jr_inflight: got we %0h ready %0h exp 0 0", ram_we, monitor_ready); end
    nxt();
    mid();
    total++; if (monitor_ready !== 1'b1 || MonDReg !== rd_data) begin bad++; $display("FAIL jr_result: got ready %0h data %h exp 1 %h", monitor_ready, MonDReg, rd_data); end
  endtask

  task automatic test_tie();
    logic [7:0] third_addr;
`ifdef NIOS2_OCIMEM_AUTOINC_EN
    third_addr = 8'h32;
`else
    third_addr = 8'h30;
`endif
    nxt(); reset = 1;
    nxt(); reset = 0;
    // c0: JTAG read lands in the slot; CPU read joins in c1 -> tie in c1.
    jtag_ld_addr = 1; jtag_rd = 1; jdo = jaddr(8'h30);
    mid();
    nxt(); cpu_read = 1; cpu_address = 8'h20;
    mid();
    total++; if (ram_addr !== 8'h30 || cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL tie1_jtag_first: got addr %h wait %0h exp 30 1", ram_addr, cpu_waitrequest); end
    nxt();
    mid();
    total++; if (cpu_waitrequest !== 1'b1 || ram_we !== 1'b0) begin bad++; $display("FAIL tie1_jtag_rd: got wait %0h we %0h exp 1 0", cpu_waitrequest, ram_we); end
    nxt();
    mid();
    total++; if (ram_addr !== 8'h20 || cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL tie1_cpu_grant: got addr %h wait %0h exp 20 1", ram_addr, cpu_waitrequest); end
    total++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hC0DE0030) begin bad++; $display("FAIL tie1_jtag_data: got %0h %h exp 1 c0de0030", monitor_ready, MonDReg); end
    nxt();
    mid();
    total++; if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'hC0DE0020) begin bad++; $display("FAIL tie1_cpu_done: got wait %0h data %h exp 0 c0de0020", cpu_waitrequest, cpu_readdata); end
    nxt(); cpu_read = 0;
    mid();
    total++; if (cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL tie1_wait_idle: got %0h exp 1", cpu_waitrequest); end
    // A lone JTAG read makes JTAG the last grant.
    nxt(); jtag_rd = 1;
    nxt(); nxt(); nxt();
    jtag_rd = 1;
    nxt(); cpu_read = 1; cpu_address = 8'h20;
    mid();
    total++; if (ram_addr !== 8'h20) begin bad++; $display("FAIL tie2_cpu_first: got addr %h exp 20", ram_addr); end
    nxt();
    mid();
    total++; if (cpu_waitrequest !== 1'b0) begin bad++; $display("FAIL tie2_cpu_done: got %0h exp 0", cpu_waitrequest); end
    nxt(); cpu_read = 0;
    mid();
    total++; if (ram_addr !== third_addr) begin bad++; $display("FAIL tie2_jtag_next: got addr %h exp %h", ram_addr, third_addr); end
    nxt(); nxt(); nxt();
  endtask

  task automatic test_write_protect();
    nxt(); cpu_write = 1; cpu_address = 8'h05; cpu_writedata = 32'h12345678;
    cpu_byteenable = 4'b0011; cpu_debugaccess = 0;
    mid();
    total++; if (cpu_waitrequest !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL wp_nodbg: got wait %0h we %0h exp 0 0", cpu_waitrequest, ram_we); end
    nxt(); cpu_debugaccess = 1;
    mid();
    total++; if (mem[8'h05] !== 32'hC0DE0005) begin bad++; $display("FAIL wp_mem_kept: got %h exp c0de0005", mem[8'h05]); end
    total++; if (cpu_waitrequest !== 1'b0 || ram_we !== 1'b1 || ram_be !== 4'b0011) begin bad++; $display("FAIL wp_dbg: got wait %0h we %0h be %0h exp 0 1 3", cpu_waitrequest, ram_we, ram_be); end
    nxt(); cpu_write = 0; cpu_debugaccess = 0; cpu_read = 1;
    mid();
    total++; if (mem[8'h05] !== 32'hC0DE5678) begin bad++; $display("FAIL wp_mem_low16: got %h exp c0de5678", mem[8'h05]); end
    nxt();
    mid();
    total++; if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'hC0DE5678) begin bad++; $display("FAIL wp_readback: got %0h %h exp 0 c0de5678", cpu_waitrequest, cpu_readdata); end
    nxt(); cpu_read = 0;
    nxt();
  endtask

  task automatic test_overrun();
    nxt(); cpu_read = 1; cpu_address = 8'h20; jtag_ld_addr = 1; jtag_rd = 1; jdo = jaddr(8'h40);
    mid();
    total++; if (ram_addr !== 8'h20) begin bad++; $display("FAIL ov_cpu_grant: got addr %h exp 20", ram_addr); end
    nxt(); jtag_rd = 1;
    mid();
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL ov_err_early: got %0h exp 0", monitor_error); end
    nxt();
    mid();
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL ov_err_set: got %0h exp 1", monitor_error); end
    total++; if (ram_addr !== 8'h40) begin bad++; $display("FAIL ov_jtag_grant: got addr %h exp 40", ram_addr); end
    nxt(); nxt();
    mid();
    total++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hC0DE0040) begin bad++; $display("FAIL ov_first_op: got %0h %h exp 1 c0de0040", monitor_ready, MonDReg); end
    nxt(); cpu_read = 0; jtag_ld_addr = 1; jdo = jaddr(8'h00);
    mid();
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL ov_err_sticky: got %0h exp 1", monitor_error); end
    nxt();
    mid();
    total++; if (monitor_error !== 1'b0 || monitor_ready !== 1'b0) begin bad++; $display("FAIL ov_ld_clear: got err %0h ready %0h exp 0 0", monitor_error, monitor_ready); end
  endtask

  task automatic test_wrap_reset();
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef NIOS2_OCIMEM_AUTOINC_EN
    rd_addr = 8'h00; rd_data = 32'hC0DE0000;
`else
    rd_addr = 8'hFF; rd_data = 32'h0BADF00D;
`endif
    nxt(); jtag_ld_addr = 1; jdo = jaddr(8'hFF);
    nxt(); jtag_wr = 1; jdo = jdata(32'h0BADF00D);
    nxt();
    mid();
    total++; if (ram_we !== 1'b1 || ram_addr !== 8'hFF) begin bad++; $display("FAIL wr_ff_write: got we %0h addr %h exp 1 ff", ram_we, ram_addr); end
    nxt(); jtag_rd = 1;
    nxt();
    mid();
    total++; if (ram_addr !== rd_addr) begin bad++; $display("FAIL wr_next_addr: got %h exp %h", ram_addr, rd_addr); end
    nxt(); nxt();
    mid();
    total++; if (monitor_ready !== 1'b1 || MonDReg !== rd_data) begin bad++; $display("FAIL wr_read_data: got %0h %h exp 1 %h", monitor_ready, MonDReg, rd_data); end
    nxt(); cpu_read = 1; cpu_address = 8'h07;
    nxt(); cpu_read = 0; reset = 1;
    cpu_write = 1; cpu_debugaccess = 1; cpu_byteenable = 4'hF; cpu_writedata = 32'hFFFFFFFF;
    mid();
    total++; if (ram_we !== 1'b0 || cpu_waitrequest !== 1'b1 || cpu_readdata !== 32'h0) begin bad++; $display("FAIL mr_in_reset: got we %0h wait %0h data %h exp 0 1 0", ram_we, cpu_waitrequest, cpu_readdata); end
    nxt(); reset = 0; cpu_write = 0; cpu_debugaccess = 0;
    mid();
    total++; if (cpu_waitrequest !== 1'b1 || ram_we !== 1'b0 || monitor_ready !== 1'b0) begin bad++; $display("FAIL mr_after: got wait %0h we %0h ready %0h exp 1 0 0", cpu_waitrequest, ram_we, monitor_ready); end
    total++; if (mem[8'h07] !== 32'hC0DE0007) begin bad++; $display("FAIL mr_mem: got %h exp c0de0007", mem[8'h07]); end
    nxt(); cpu_read = 1; cpu_address = 8'h07;
    mid();
    total++; if (ram_addr !== 8'h07 || cpu_waitrequest !== 1'b1) begin bad++; $display("FAIL mr_idle_grant: got addr %h wait %0h exp 07 1", ram_addr, cpu_waitrequest); end
    nxt();
    mid();
    total++; if (cpu_waitrequest !== 1'b0 || cpu_readdata !== 32'hC0DE0007) begin bad++; $display("FAIL mr_read: got %0h %h exp 0 c0de0007", cpu_waitrequest, cpu_readdata); end
    nxt(); cpu_read = 0;
    nxt();
  endtask

  initial begin
    test_reset();
    test_jtag_wr_rd();
    test_tie();
    test_write_protect();
    test_overrun();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
